// File: rtl/adder_check_monitor.sv
// adder_check_monitor
//   Result monitor sitting behind the 16-bit dual-adder checker. It counts
//   accepted check beats and mismatching beats over a bounded run, keeps a
//   sticky OR of every mismatch bit seen, and holds the operands and check
//   vector of the first failing beat for debug readout.
//
//   Optional build macro: ADDCHK_STOP_ON_ERR_EN
//     defined   -> the first mismatching beat in RUN ends the run (goes DONE)
//     undefined -> the run always continues to NUM_VEC beats (or forever if 0)
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   start               pulse: zero stats and begin a run
//   clear               pulse: zero stats and return to IDLE (wins over start)
//   in_valid            check/operand beat present this cycle
//   in_a, in_b          operands that produced the check vector
//   check, checkcout    per-bit sum mismatch and carry-out mismatch
//   busy, done, pass    run status (pass = done with zero errors)
//   vec_count           accepted beats this run (saturating)
//   err_count           mismatching beats this run (saturating)
//   err_mask            sticky OR of {checkcout, check}
//   first_valid         first-failure capture held
//   first_a, first_b    operands of first failing beat
//   first_check         {checkcout, check} of first failing beat

// Saturating up-counter with synchronous clear; holds at all-ones.
module adder_check_sat_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (inc && (count != {W{1'b1}}))
            count <= count + 1'b1;
    end
endmodule

module adder_check_monitor #(
    parameter int WIDTH   = 16,
    parameter int CNT_W   = 16,
    parameter int NUM_VEC = 1000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             clear,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] check,
    input  logic             checkcout,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] vec_count,
    output logic [CNT_W-1:0] err_count,
    output logic [WIDTH:0]   err_mask,
    output logic             first_valid,
    output logic [WIDTH-1:0] first_a,
    output logic [WIDTH-1:0] first_b,
    output logic [WIDTH:0]   first_check
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

`ifdef ADDCHK_STOP_ON_ERR_EN
    localparam bit STOP_ON_ERR = 1'b1;
`else
    localparam bit STOP_ON_ERR = 1'b0;
`endif

    localparam bit             BOUNDED  = (NUM_VEC != 0);
    // vec_count value seen on the edge that accepts the final beat. Since
    // NUM_VEC fits in CNT_W, vec_count has not saturated by then, so the
    // visible counter doubles as the run-length counter.
    localparam logic [CNT_W-1:0] LAST_CNT = BOUNDED ? CNT_W'(NUM_VEC - 1) : '0;

    state_t state, state_nxt;

    logic stats_clr;
    logic accept;
    logic mismatch;
    logic err_inc;
    logic last_beat;
    logic end_run;

    // start or clear both wipe the stats; a beat on a restart edge is dropped.
    assign stats_clr = start | clear;
    assign accept    = (state == RUN) & in_valid & ~stats_clr;
    assign mismatch  = (|check) | checkcout;
    assign err_inc   = accept & mismatch;
    assign last_beat = BOUNDED & (vec_count == LAST_CNT);
    assign end_run   = accept & (last_beat | (STOP_ON_ERR & mismatch));

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (clear)
            state_nxt = IDLE;
        else if (start)
            state_nxt = RUN;
        else if (end_run)
            state_nxt = DONE;
    end

    // ---------------------------------------------------------- counters
    logic [1:0]            cnt_inc;
    logic [1:0][CNT_W-1:0] cnt_val;

    assign cnt_inc = {err_inc, accept};

    for (genvar g = 0; g < 2; g++) begin : g_cnt
        adder_check_sat_cnt #(.W(CNT_W)) u_cnt (
            .clk   (clk),
            .rst_n (rst_n),
            .clr   (stats_clr),
            .inc   (cnt_inc[g]),
            .count (cnt_val[g])
        );
    end

    assign vec_count = cnt_val[0];
    assign err_count = cnt_val[1];

    // --------------------------------------------- sticky mask / capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_mask    <= '0;
            first_valid <= 1'b0;
            first_a     <= '0;
            first_b     <= '0;
            first_check <= '0;
        end else if (stats_clr) begin
            err_mask    <= '0;
            first_valid <= 1'b0;
            first_a     <= '0;
            first_b     <= '0;
            first_check <= '0;
        end else if (err_inc) begin
            err_mask <= err_mask | {checkcout, check};
            if (!first_valid) begin
                first_valid <= 1'b1;
                first_a     <= in_a;
                first_b     <= in_b;
                first_check <= {checkcout, check};
            end
        end
    end

    // ------------------------------------------------------ status flops
    // Status is registered from the next state so it lines up with the
    // counters. pass looks ahead at err_count: it is zero after this edge
    // only if it is zero now and this edge does not add an error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 1'b0;
            done <= 1'b0;
            pass <= 1'b0;
        end else begin
            busy <= (state_nxt == RUN);
            done <= (state_nxt == DONE);
            pass <= (state_nxt == DONE) & (err_count == '0) & ~err_inc;
        end
    end
endmodule
